// File: rtl/sao_stat_mask_scan.sv
// Raster scan of one CTU in pixel groups, producing a registered per-EO-class
// "use this pixel" mask that accounts for CTU edges, picture clipping and neighbour availability.
module sao_stat_mask_scan #(
  parameter int N_PIX     = 4,
  parameter int N_EO_TYPE = 4,
  parameter int BLK_X_LEN = 6,
  parameter int BLK_Y_LEN = 6,
  parameter int CTU_LEN   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CTU_LEN-1:0]   valid_w,
  input  logic [CTU_LEN-1:0]   valid_h,
  input  logic [7:0]           avail,
  output logic                 idle,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [BLK_X_LEN-1:0] o_x,
  output logic [BLK_Y_LEN-1:0] o_y,
  output logic                 o_last,
  output logic [N_PIX-1:0]     b_use [0:N_EO_TYPE-1],
  output logic                 o_done
);

  localparam int GW = N_PIX / 2;
  localparam int CW = CTU_LEN + 1;
  localparam logic signed [CW-1:0] S_ZERO = {CW{1'b0}};
  localparam logic signed [CW-1:0] S_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [BLK_X_LEN-1:0] X_ONE  = {{(BLK_X_LEN-1){1'b0}}, 1'b1};
  localparam logic [BLK_Y_LEN-1:0] Y_ONE  = {{(BLK_Y_LEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CTU_LEN-1:0]   w_q, h_q;
  logic [7:0]           av_q;
  logic [BLK_X_LEN-1:0] gx_q, nxm1_q, ox_q;
  logic [BLK_Y_LEN-1:0] gy_q, nym1_q, oy_q;
  logic                 valid_q, last_q, done_q, idle_q, done_d;
  logic                 load_s, ctu_empty_s, last_grp_s;
  logic [N_PIX-1:0]     b_use_q [0:N_EO_TYPE-1];
  logic [N_PIX-1:0]     b_use_d [0:N_EO_TYPE-1];

  // Neighbour availability from the side it lies on relative to the clipped CTU area.
  function automatic logic nb_avail(input logic signed [CW-1:0] nx, input logic signed [CW-1:0] ny,
                                    input logic signed [CW-1:0] ws, input logic signed [CW-1:0] hs,
                                    input logic [7:0] av);
    logic [1:0] sx, sy;
    if (nx < S_ZERO)   sx = 2'd1;
    else if (nx >= ws) sx = 2'd2;
    else               sx = 2'd0;
    if (ny < S_ZERO)   sy = 2'd1;
    else if (ny >= hs) sy = 2'd2;
    else               sy = 2'd0;
    case ({sx, sy})
      4'b0000: nb_avail = 1'b1;
      4'b0100: nb_avail = av[0];
      4'b1000: nb_avail = av[1];
      4'b0001: nb_avail = av[2];
      4'b0010: nb_avail = av[3];
      4'b0101: nb_avail = av[4];
      4'b1001: nb_avail = av[5];
      4'b0110: nb_avail = av[6];
      4'b1010: nb_avail = av[7];
      default: nb_avail = 1'b0;
    endcase
  endfunction

  // The two neighbours of a class are always mirror images, so one offset suffices.
  function automatic logic use_bit(input logic [BLK_X_LEN-1:0] gx, input logic [BLK_Y_LEN-1:0] gy,
                                   input int p, input int e, input logic [CTU_LEN-1:0] w,
                                   input logic [CTU_LEN-1:0] h, input logic [7:0] av);
    logic signed [CW-1:0] px, py, dx, dy, ws, hs;
    px = CW'(int'(gx) * GW + 2 * (p / 4) + (p % 2));
    py = CW'(int'(gy) * 2 + (p % 4) / 2);
    ws = {1'b0, w};
    hs = {1'b0, h};
    case (e)
      0:       begin dx = S_ONE;  dy = S_ZERO; end
      1:       begin dx = S_ZERO; dy = S_ONE;  end
      2:       begin dx = S_ONE;  dy = S_ONE;  end
      3:       begin dx = S_ONE;  dy = -S_ONE; end
      default: begin dx = S_ZERO; dy = S_ZERO; end
    endcase
    use_bit = (px < ws) && (py < hs) && nb_avail(px + dx, py + dy, ws, hs, av)
              && nb_avail(px - dx, py - dy, ws, hs, av);
  endfunction

  assign ctu_empty_s = (w_q == {CTU_LEN{1'b0}}) || (h_q == {CTU_LEN{1'b0}});
  assign last_grp_s  = (gx_q == nxm1_q) && (gy_q == nym1_q);

  // Scan state machine: next state and per-cycle strobes.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SETUP;
        else       state_d = S_IDLE;
      end
      S_SETUP: begin
        if (ctu_empty_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!valid_q || o_ready) begin
          load_s = 1'b1;
          if (last_grp_s) state_d = S_FLUSH;
          else            state_d = S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        if (valid_q && o_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Mask for the group currently addressed by the scan counters.
  always_comb begin
    for (int e = 0; e < N_EO_TYPE; e++) begin
      b_use_d[e] = {N_PIX{1'b0}};
      for (int p = 0; p < N_PIX; p++) begin
        b_use_d[e][p] = use_bit(gx_q, gy_q, p, e, w_q, h_q, av_q);
      end
    end
  end

  // State, latched CTU configuration, scan counters and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      w_q     <= {CTU_LEN{1'b0}};
      h_q     <= {CTU_LEN{1'b0}};
      av_q    <= 8'h00;
      gx_q    <= {BLK_X_LEN{1'b0}};
      gy_q    <= {BLK_Y_LEN{1'b0}};
      nxm1_q  <= {BLK_X_LEN{1'b0}};
      nym1_q  <= {BLK_Y_LEN{1'b0}};
      ox_q    <= {BLK_X_LEN{1'b0}};
      oy_q    <= {BLK_Y_LEN{1'b0}};
      for (int e = 0; e < N_EO_TYPE; e++) b_use_q[e] <= {N_PIX{1'b0}};
    end else begin
      state_q <= state_d;
      idle_q  <= (state_d == S_IDLE);
      done_q  <= done_d;
      if (state_q == S_IDLE && start) begin
        w_q  <= valid_w;
        h_q  <= valid_h;
        av_q <= avail;
        gx_q <= {BLK_X_LEN{1'b0}};
        gy_q <= {BLK_Y_LEN{1'b0}};
      end
      // Group counts are ceil(w/GW) and ceil(h/2); an empty CTU never reaches RUN.
      if (state_q == S_SETUP) begin
        nxm1_q <= BLK_X_LEN'((int'(w_q) + GW - 1) / GW - 1);
        nym1_q <= BLK_Y_LEN'((int'(h_q) + 1) / 2 - 1);
      end
      if (load_s) begin
        valid_q <= 1'b1;
        last_q  <= last_grp_s;
        ox_q    <= gx_q;
        oy_q    <= gy_q;
        b_use_q <= b_use_d;
        if (gx_q == nxm1_q) begin
          gx_q <= {BLK_X_LEN{1'b0}};
          gy_q <= gy_q + Y_ONE;
        end else begin
          gx_q <= gx_q + X_ONE;
        end
      end else if (state_q == S_FLUSH && o_ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign idle    = idle_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_x     = ox_q;
  assign o_y     = oy_q;
  assign o_done  = done_q;
  assign b_use   = b_use_q;

endmodule
